// File: rtl/port_status_monitor.sv
// Per-port status front end: debounced PHY link, TX/RX frame-end pulses,
// shared blink square wave and saturating per-direction frame counters.
`timescale 1ns/1ps

module port_status_monitor #(
    parameter int unsigned BLINK_DIV     = 12500000,
    parameter int unsigned LINK_DEBOUNCE = 1000000,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             link_raw_i,
    input  logic             tx_tvalid_i,
    input  logic             tx_tready_i,
    input  logic             tx_tlast_i,
    input  logic             rx_tvalid_i,
    input  logic             rx_tready_i,
    input  logic             rx_tlast_i,
    input  logic             count_clear_i,
    output logic             has_link_o,
    output logic             on_frame_sent_o,
    output logic             on_frame_received_o,
    output logic             blink_o,
    output logic [CNT_W-1:0] tx_frame_count_o,
    output logic [CNT_W-1:0] rx_frame_count_o
);

    localparam int unsigned DEB_W = $clog2(LINK_DEBOUNCE);
    localparam int unsigned BLK_W = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {
        LINK_DOWN,
        LINK_UP_PEND,
        LINK_UP,
        LINK_DOWN_PEND
    } link_state_t;

    link_state_t      link_state;
    logic [DEB_W-1:0] deb_cnt;
    logic [BLK_W-1:0] blink_cnt;
    logic             deb_last;
    logic             tx_fire;
    logic             rx_fire;

    assign deb_last = (deb_cnt == DEB_W'(LINK_DEBOUNCE - 1));
    assign tx_fire  = tx_tvalid_i & tx_tready_i & tx_tlast_i;
    assign rx_fire  = rx_tvalid_i & rx_tready_i & rx_tlast_i;

    // Link qualification: any opposite-level sample inside a pending state
    // abandons the qualification and returns to the stable state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            link_state <= LINK_DOWN;
            deb_cnt    <= '0;
            has_link_o <= 1'b0;
        end else begin
            case (link_state)
                LINK_DOWN: begin
                    if (link_raw_i) begin
                        link_state <= LINK_UP_PEND;
                        deb_cnt    <= DEB_W'(1);
                    end
                end
                LINK_UP_PEND: begin
                    if (!link_raw_i) begin
                        link_state <= LINK_DOWN;
                    end else if (deb_last) begin
                        link_state <= LINK_UP;
                        has_link_o <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                LINK_UP: begin
                    if (!link_raw_i) begin
                        link_state <= LINK_DOWN_PEND;
                        deb_cnt    <= DEB_W'(1);
                    end
                end
                LINK_DOWN_PEND: begin
                    if (link_raw_i) begin
                        link_state <= LINK_UP;
                    end else if (deb_last) begin
                        link_state <= LINK_DOWN;
                        has_link_o <= 1'b0;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                default: begin
                    link_state <= LINK_DOWN;
                    deb_cnt    <= '0;
                    has_link_o <= 1'b0;
                end
            endcase
        end
    end

    // Blink half-period divider.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            blink_cnt <= '0;
            blink_o   <= 1'b0;
        end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_o   <= ~blink_o;
        end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
        end
    end

    // TX frame-end pulse and saturating counter; clear with a beat loads 1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            on_frame_sent_o  <= 1'b0;
            tx_frame_count_o <= '0;
        end else begin
            on_frame_sent_o <= tx_fire;
            if (count_clear_i) begin
                tx_frame_count_o <= tx_fire ? CNT_W'(1) : '0;
            end else if (tx_fire && (tx_frame_count_o != '1)) begin
                tx_frame_count_o <= tx_frame_count_o + CNT_W'(1);
            end
        end
    end

    // RX frame-end pulse and saturating counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            on_frame_received_o <= 1'b0;
            rx_frame_count_o    <= '0;
        end else begin
            on_frame_received_o <= rx_fire;
            if (count_clear_i) begin
                rx_frame_count_o <= rx_fire ? CNT_W'(1) : '0;
            end else if (rx_fire && (rx_frame_count_o != '1)) begin
                rx_frame_count_o <= rx_frame_count_o + CNT_W'(1);
            end
        end
    end

endmodule
